// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine.
// Formats loads/stores, drives a req/ready data-memory port, and registers
// results toward write-back. Holds EX/MEM via o_stall while an access is open.
// Optional macro: MISALIGN_TRAP_EN (misaligned half/word accesses are not
// issued and raise a one-cycle o_misalign pulse instead of being masked).
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_wr,
  input  logic [4:0]        i_rd_addr,
  input  logic [5:0]        i_mnemonic,
  input  logic [31:0]       i_ALUout,
  input  logic [31:0]       i_rs2_data,
  output logic              o_stall,
  output logic              o_dm_req,
  output logic              o_dm_we,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [3:0]        o_dm_wstrb,
  output logic [31:0]       o_dm_wdata,
  input  logic              i_dm_ready,
  input  logic [31:0]       i_dm_rdata,
  output logic              o_misalign,
  output logic              o_rd_wr,
  output logic [4:0]        o_rd_addr,
  output logic [31:0]       o_rd_data
);

  localparam logic [5:0] MN_LB  = 6'd11;
  localparam logic [5:0] MN_LH  = 6'd12;
  localparam logic [5:0] MN_LW  = 6'd13;
  localparam logic [5:0] MN_LBU = 6'd14;
  localparam logic [5:0] MN_LHU = 6'd15;
  localparam logic [5:0] MN_SB  = 6'd16;
  localparam logic [5:0] MN_SH  = 6'd17;
  localparam logic [5:0] MN_SW  = 6'd18;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [2:0] {EXT_B, EXT_BU, EXT_H, EXT_HU, EXT_W} ext_t;

  state_t      state;
  ext_t        ld_ext;
  logic [1:0]  ld_off;
  logic        ld_is_load;
  logic        ld_rd_wr;
  logic [4:0]  ld_rd_addr;

  logic        is_load, is_store, is_mem;
  logic        sz_b, sz_h, sz_w;
  logic        trap;
  logic [1:0]  off;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  ext_t        ext;
  logic [31:0] lane;
  logic [31:0] load_data;

  // Decode the incoming op and pre-format store strobes/data
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_b     = 1'b0;
    sz_h     = 1'b0;
    sz_w     = 1'b0;
    ext      = EXT_W;
    case (i_mnemonic)
      MN_LB:  begin is_load  = 1'b1; sz_b = 1'b1; ext = EXT_B;  end
      MN_LBU: begin is_load  = 1'b1; sz_b = 1'b1; ext = EXT_BU; end
      MN_LH:  begin is_load  = 1'b1; sz_h = 1'b1; ext = EXT_H;  end
      MN_LHU: begin is_load  = 1'b1; sz_h = 1'b1; ext = EXT_HU; end
      MN_LW:  begin is_load  = 1'b1; sz_w = 1'b1; end
      MN_SB:  begin is_store = 1'b1; sz_b = 1'b1; end
      MN_SH:  begin is_store = 1'b1; sz_h = 1'b1; end
      MN_SW:  begin is_store = 1'b1; sz_w = 1'b1; end
      default: ;
    endcase
    is_mem = is_load | is_store;
    // Offset is forced to natural alignment; only matters when not trapping
    if (sz_b)      off = i_ALUout[1:0];
    else if (sz_h) off = {i_ALUout[1], 1'b0};
    else           off = 2'b00;
    wstrb = '0;
    wdata = '0;
    if (is_store) begin
      if (sz_b) begin
        wstrb = 4'b0001 << off;
        wdata = {4{i_rs2_data[7:0]}};
      end else if (sz_h) begin
        wstrb = 4'b0011 << off;
        wdata = {2{i_rs2_data[15:0]}};
      end else begin
        wstrb = 4'b1111;
        wdata = i_rs2_data;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = is_mem & ((sz_h & i_ALUout[0]) | (sz_w & (|i_ALUout[1:0])));
`else
  assign trap = 1'b0;
`endif

  // Stall while a memory op waits in IDLE or is outstanding in REQ
  always_comb begin
    o_stall = (state == REQ) || ((state == IDLE) && is_mem);
  end

  // Extract and extend the addressed lane of the returned word
  always_comb begin
    lane = i_dm_rdata >> {ld_off, 3'b000};
    case (ld_ext)
      EXT_B:   load_data = {{24{lane[7]}}, lane[7:0]};
      EXT_BU:  load_data = {24'h0, lane[7:0]};
      EXT_H:   load_data = {{16{lane[15]}}, lane[15:0]};
      EXT_HU:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // Access FSM with registered memory-port and write-back outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      o_dm_req   <= 1'b0;
      o_dm_we    <= 1'b0;
      o_dm_addr  <= '0;
      o_dm_wstrb <= '0;
      o_dm_wdata <= '0;
      o_misalign <= 1'b0;
      o_rd_wr    <= 1'b0;
      o_rd_addr  <= '0;
      o_rd_data  <= '0;
      ld_ext     <= EXT_W;
      ld_off     <= '0;
      ld_is_load <= 1'b0;
      ld_rd_wr   <= 1'b0;
      ld_rd_addr <= '0;
    end else begin
      o_misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem) begin
            o_rd_wr <= 1'b0;
            if (trap) begin
              o_misalign <= 1'b1;
              state      <= DONE;
            end else begin
              o_dm_req   <= 1'b1;
              o_dm_we    <= is_store;
              o_dm_addr  <= {i_ALUout[ADDR_W-1:2], 2'b00};
              o_dm_wstrb <= wstrb;
              o_dm_wdata <= wdata;
              ld_ext     <= ext;
              ld_off     <= off;
              ld_is_load <= is_load;
              ld_rd_wr   <= i_rd_wr;
              ld_rd_addr <= i_rd_addr;
              state      <= REQ;
            end
          end else begin
            o_rd_wr   <= i_rd_wr;
            o_rd_addr <= i_rd_addr;
            o_rd_data <= i_ALUout;
          end
        end
        REQ: begin
          if (i_dm_ready) begin
            o_dm_req <= 1'b0;
            state    <= DONE;
            if (ld_is_load) begin
              o_rd_wr   <= ld_rd_wr;
              o_rd_addr <= ld_rd_addr;
              o_rd_data <= load_data;
            end else begin
              o_rd_wr <= 1'b0;
            end
          end
        end
        DONE: begin
          o_rd_wr <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store engine that consumes the EX/MEM pipeline register outputs and drives the data-memory port through a request/ready handshake. Loads and stores are formatted here: byte-lane strobes, shifted store data, sign/zero-extended load data. Results are registered toward write-back. Upstream EX/MEM is held through `o_stall` while an access is outstanding.

## Interface
- `ADDR_W`, default 32: data-memory address width; bits above `ADDR_W-1` of the effective address are dropped.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_rd_wr`  in  1  rd write enable from EX/MEM.
- `i_rd_addr`  in  5  destination register.
- `i_mnemonic`  in  6  operation code: LB=11, LH=12, LW=13, LBU=14, LHU=15, SB=16, SH=17, SW=18; every other value is a non-memory op.
- `i_ALUout`  in  32  effective address for memory ops, result for others.
- `i_rs2_data`  in  32  store source.
- `o_stall`  out  1  hold EX/MEM (combinational).
- `o_dm_req`  out  1  memory request valid.
- `o_dm_we`  out  1  1 = store.
- `o_dm_addr`  out  ADDR_W  word-aligned address, low 2 bits 0.
- `o_dm_wstrb`  out  4  byte-lane write strobes; 0 for loads.
- `o_dm_wdata`  out  32  lane-shifted store data.
- `i_dm_ready`  in  1  request accepted or completed this cycle.
- `i_dm_rdata`  in  32  read word, valid when `i_dm_ready`=1 on a load.
- `o_misalign`  out  1  one-cycle misaligned-access pulse (macro-dependent).
- `o_rd_wr`, `o_rd_addr` (5), `o_rd_data` (32)  out  registered write-back outputs.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE, non-memory op: next edge `o_rd_wr`←`i_rd_wr`, `o_rd_addr`←`i_rd_addr`, `o_rd_data`←`i_ALUout`. `o_stall`=0.
- IDLE, memory op: `o_stall`=1. Latch addr, we, wstrb, wdata, extension type, byte offset, and rd. Go to REQ. `o_rd_wr`←0 (bubble).
- REQ: `o_dm_req`=1 with latched fields stable. `o_stall`=1, `o_rd_wr`=0.
  - `i_dm_ready`=0: stay in REQ.
  - `i_dm_ready`=1: go to DONE.
  - Load completion: `o_rd_data`←extended lane, `o_rd_wr`←latched rd_wr, `o_rd_addr`←latched rd.
  - Store completion: `o_rd_wr`←0.
- DONE: `o_stall`=0, `o_dm_req`=0, `o_rd_wr`←0 at the edge. Inputs are ignored; EX/MEM advances at the end of this cycle. Next state is IDLE.
- Store formatting, with offset = addr[1:0]:
  - SB: wstrb = 0001<<offset, wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 0011<<offset, wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111, wdata = rs2.
- Load formatting: select the byte or halfword at the offset.
  - LB/LH sign-extend to 32 bits.
  - LBU/LHU zero-extend to 32 bits.
  - LW passes the word through.
- Reset values: `o_stall`=0 while idle with no memory op. All other outputs are 0: `o_dm_req`, `o_dm_we`, `o_dm_addr`, `o_dm_wstrb`, `o_dm_wdata`, `o_misalign`, `o_rd_wr`, `o_rd_addr`, `o_rd_data`.
- Reset mid-access (REQ with `i_dm_ready`=0): at the edge, `o_dm_req` drops and state goes to IDLE. The pending load does not reach write-back.

## Timing
- Non-memory op: 1-cycle latency to `o_rd_*`.
- Memory op presented in IDLE at cycle N:
  - `o_dm_req` rises at N+1.
  - With `i_dm_ready`=1 at N+k (k≥1), `o_rd_*` are updated at N+k+1 (DONE).
  - `o_stall` is high from N through N+k and low at N+k+1.
  - Minimum occupancy is 3 cycles per memory op.
- Handshake: `o_dm_req` and all `o_dm_*` fields stay constant from the rise of `o_dm_req` until the cycle `i_dm_ready`=1. Exactly one request is issued per memory op. `i_dm_ready` outside REQ is ignored.
- Write-back outputs change only at clock edges. `o_stall` is combinational from state and `i_mnemonic`.

## Configuration
- `MISALIGN_TRAP_EN` defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠0, is not issued.
  - The IDLE→DONE path is taken directly, with a single stall cycle.
  - `o_misalign` is 1 for one cycle (registered, during DONE).
  - `o_rd_wr`=0.
- `MISALIGN_TRAP_EN` undefined: the low address bits are masked to natural alignment (halfword: addr[0]=0; word: addr[1:0]=0) and the access proceeds. `o_misalign` is tied to 0.

## Test plan
- ADD result 0x0000_1234, rd=5, rd_wr=1 in IDLE → next cycle `o_rd_data`=0x1234, `o_rd_addr`=5, `o_rd_wr`=1, `o_stall` never high.
- LB at addr 0x103, rdata 0x80FF_FFFF, ready after 2 REQ cycles:
  - `o_dm_addr`=0x100 and `o_dm_wstrb`=0 are held stable.
  - `o_rd_data`=0xFFFF_FF80.
  - `o_stall` high for 3 cycles.
- LHU at addr 0x202, rdata 0x8001_0000, ready immediately → `o_rd_data`=0x0000_8001, 3-cycle occupancy.
- SH at addr 0x0A2, rs2=0xDEAD_BEEF → `o_dm_we`=1, `o_dm_wstrb`=1100, `o_dm_wdata`=0xBEEF_BEEF, `o_rd_wr` stays 0.
- SW at addr 0x10 with ready held low 5 cycles, `rst` pulsed in cycle 3 → `o_dm_req`=0 and all outputs 0 the cycle after reset, state IDLE.
- LW at addr 0x06:
  - With `MISALIGN_TRAP_EN`: no `o_dm_req`, `o_misalign` is a one-cycle pulse, `o_rd_wr`=0.
  - Without it: `o_dm_addr`=0x04 and the access completes normally.
